control_unit: RTL and testbench

//  Control sequencer for the datapath. Decodes the opcode fed back from
//  the IR and drives every datapath control strobe, one state per clock.

---
 rtl/control_unit_if.sv | 42 ++++
 rtl/control_unit.sv | 211 +++++++++++++++++++++
 tb/tb_control_unit.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// control_unit_if
//  Groups the sequencer's datapath-facing signals into one interface.
//  master: the control unit. It reads opcode, CON_FF and Stop, and drives Run,
//          every bus-driver strobe, load strobe, memory strobe,
//          register-select strobe and the one-hot REGin vector.
//  slave : the datapath side of the same signals.
//  OPW  : opcode width (IR[31:27]).
//  NREG : width of the one-hot REGin direct-load vector.
interface control_unit_if #(
    parameter int OPW  = 5,
    parameter int NREG = 16
);
    logic [OPW-1:0]  opcode;
    logic            CON_FF;
    logic            Stop;
    logic            Run;
    logic            PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortOut;
    logic            PCin, MARin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin, CONin, OutPortIn;
    logic            IncPC, Read, RAMin;
    logic            GRA, GRB, GRC, BAout, Rin, Rout;
    logic [NREG-1:0] REGin;

    modport master (
        input  opcode, CON_FF, Stop,
        output Run,
        output PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortOut,
        output PCin, MARin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin, CONin, OutPortIn,
        output IncPC, Read, RAMin,
        output GRA, GRB, GRC, BAout, Rin, Rout,
        output REGin
    );

    modport slave (
        output opcode, CON_FF, Stop,
        input  Run,
        input  PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, InPortOut,
        input  PCin, MARin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin, CONin, OutPortIn,
        input  IncPC, Read, RAMin,
        input  GRA, GRB, GRC, BAout, Rin, Rout,
        input  REGin
    );
endinterface

// File: rtl/control_unit.sv
// control_unit
//  Control sequencer for the datapath, advancing one state per clock.
//  Every instruction fetches in T0-T2. It then runs a per-opcode execute
//  sequence (T3..T7), and returns to T0. A halt instruction, or Stop seen in
//  an instruction's last state, parks the sequencer in HALT until clr.
//  Ports:
//   clk : clock. All state changes happen on posedge.
//   clr : asynchronous, active-low reset. While it is low the state is RST
//         and every output is 0.
//   bus : control_unit_if.master. It carries opcode, CON_FF and Stop in,
//         and carries Run plus every datapath strobe out.
module control_unit #(
    parameter int OPW  = 5,
    parameter int NREG = 16
) (
    input  logic           clk,
    input  logic           clr,
    control_unit_if.master bus
);

    localparam logic [OPW-1:0] OP_LD   = OPW'(0);
    localparam logic [OPW-1:0] OP_LDI  = OPW'(1);
    localparam logic [OPW-1:0] OP_ST   = OPW'(2);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
    localparam logic [OPW-1:0] OP_ROL  = OPW'(11);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(12);
    localparam logic [OPW-1:0] OP_ORI  = OPW'(14);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(15);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(16);
    localparam logic [OPW-1:0] OP_NEG  = OPW'(17);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(18);
    localparam logic [OPW-1:0] OP_BR   = OPW'(19);
    localparam logic [OPW-1:0] OP_JR   = OPW'(20);
    localparam logic [OPW-1:0] OP_JAL  = OPW'(21);
    localparam logic [OPW-1:0] OP_IN   = OPW'(22);
    localparam logic [OPW-1:0] OP_OUT  = OPW'(23);
    localparam logic [OPW-1:0] OP_MFHI = OPW'(24);
    localparam logic [OPW-1:0] OP_MFLO = OPW'(25);
    localparam logic [OPW-1:0] OP_HALT = OPW'(27);

    // jal saves the return address straight into register 15
    localparam logic [NREG-1:0] JAL_REGIN = NREG'(1) << 15;

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_e;

    typedef enum logic [3:0] {
        C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_MULDIV, C_NEGNOT, C_BR,
        C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
    } op_class_e;

    state_e    state, next_state, end_state;
    op_class_e op_class;

    // State register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= S_RST;
        else      state <= next_state;
    end

    // Opcodes that share an execute sequence are folded into one class.
    // nop and the undefined opcodes both fall through to C_NOP.
    always_comb begin
        op_class = C_NOP;
        case (bus.opcode) inside
            OP_LD:               op_class = C_LD;
            OP_LDI:              op_class = C_LDI;
            OP_ST:               op_class = C_ST;
            [OP_ADD:OP_ROL]:     op_class = C_ALU;
            [OP_ADDI:OP_ORI]:    op_class = C_IMM;
            OP_MUL, OP_DIV:      op_class = C_MULDIV;
            OP_NEG, OP_NOT:      op_class = C_NEGNOT;
            OP_BR:               op_class = C_BR;
            OP_JR:               op_class = C_JR;
            OP_JAL:              op_class = C_JAL;
            OP_IN:               op_class = C_IN;
            OP_OUT:              op_class = C_OUT;
            OP_MFHI:             op_class = C_MFHI;
            OP_MFLO:             op_class = C_MFLO;
            OP_HALT:             op_class = C_HALT;
            default:             op_class = C_NOP;
        endcase
    end

    // Last execute state of each class. Stop is honoured only in that state,
    // so an instruction already in flight always finishes.
    always_comb begin
        end_state = S_T3;
        case (op_class)
            C_LD, C_ST:             end_state = S_T7;
            C_LDI, C_ALU, C_IMM:    end_state = S_T5;
            C_MULDIV, C_BR:         end_state = S_T6;
            C_NEGNOT, C_JAL:        end_state = S_T4;
            default:                end_state = S_T3;
        endcase
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_RST:  next_state = S_T0;
            S_T0:   next_state = S_T1;
            S_T1:   next_state = S_T2;
            S_T2:   next_state = S_T3;
            S_HALT: next_state = S_HALT;
            default: begin
                if (op_class == C_HALT)       next_state = S_HALT;
                else if (state == end_state)  next_state = bus.Stop ? S_HALT : S_T0;
                else                          next_state = state_e'(state + 4'd1);
            end
        endcase
    end

    // Strobe decode. Every strobe defaults to 0, and each state raises only
    // its own set. The one exception is br, where PCin in T6 follows CON_FF
    // in that same cycle.
    always_comb begin
        bus.PCout = 1'b0; bus.ZLowout = 1'b0; bus.ZHighout = 1'b0; bus.MDRout = 1'b0;
        bus.HIout = 1'b0; bus.LOout = 1'b0; bus.Cout = 1'b0; bus.InPortOut = 1'b0;
        bus.PCin = 1'b0; bus.MARin = 1'b0; bus.MDRin = 1'b0; bus.IRin = 1'b0;
        bus.Yin = 1'b0; bus.ZLowIn = 1'b0; bus.ZHighIn = 1'b0; bus.HIin = 1'b0;
        bus.LOin = 1'b0; bus.CONin = 1'b0; bus.OutPortIn = 1'b0;
        bus.IncPC = 1'b0; bus.Read = 1'b0; bus.RAMin = 1'b0;
        bus.GRA = 1'b0; bus.GRB = 1'b0; bus.GRC = 1'b0; bus.BAout = 1'b0;
        bus.Rin = 1'b0; bus.Rout = 1'b0;
        bus.REGin = '0;
        bus.Run = (state != S_RST) && (state != S_HALT);

        case (state)
            S_T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.ZLowIn = 1'b1; end
            S_T1: begin bus.ZLowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1; end
            S_T2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                case (op_class)
                    C_LD, C_LDI, C_ST: begin
                        case (state)
                            S_T3: begin bus.GRB = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1; end
                            S_T4: begin bus.Cout = 1'b1; bus.ZLowIn = 1'b1; end
                            S_T5: begin
                                bus.ZLowout = 1'b1;
                                if (op_class == C_LDI) begin bus.GRA = 1'b1; bus.Rin = 1'b1; end
                                else                   bus.MARin = 1'b1;
                            end
                            S_T6: begin
                                bus.MDRin = 1'b1;
                                if (op_class == C_LD) bus.Read = 1'b1;
                                else begin bus.GRA = 1'b1; bus.Rout = 1'b1; end
                            end
                            S_T7: begin
                                if (op_class == C_LD) begin bus.MDRout = 1'b1; bus.GRA = 1'b1; bus.Rin = 1'b1; end
                                else                  bus.RAMin = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    C_ALU, C_IMM: begin
                        case (state)
                            S_T3: begin bus.GRB = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
                            S_T4: begin
                                bus.ZLowIn = 1'b1;
                                if (op_class == C_IMM) bus.Cout = 1'b1;
                                else begin bus.GRC = 1'b1; bus.Rout = 1'b1; end
                            end
                            S_T5: begin bus.ZLowout = 1'b1; bus.GRA = 1'b1; bus.Rin = 1'b1; end
                            default: ;
                        endcase
                    end
                    C_MULDIV: begin
                        case (state)
                            S_T3: begin bus.GRA = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
                            S_T4: begin bus.GRB = 1'b1; bus.Rout = 1'b1; bus.ZHighIn = 1'b1; bus.ZLowIn = 1'b1; end
                            S_T5: begin bus.ZLowout = 1'b1; bus.LOin = 1'b1; end
                            S_T6: begin bus.ZHighout = 1'b1; bus.HIin = 1'b1; end
                            default: ;
                        endcase
                    end
                    C_NEGNOT: begin
                        case (state)
                            S_T3: begin bus.GRB = 1'b1; bus.Rout = 1'b1; bus.ZLowIn = 1'b1; end
                            S_T4: begin bus.ZLowout = 1'b1; bus.GRA = 1'b1; bus.Rin = 1'b1; end
                            default: ;
                        endcase
                    end
                    C_BR: begin
                        case (state)
                            S_T3: begin bus.GRA = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1; end
                            S_T4: begin bus.PCout = 1'b1; bus.Yin = 1'b1; end
                            S_T5: begin bus.Cout = 1'b1; bus.ZLowIn = 1'b1; end
                            S_T6: begin bus.ZLowout = 1'b1; bus.PCin = bus.CON_FF; end
                            default: ;
                        endcase
                    end
                    C_JR:   if (state == S_T3) begin bus.GRA = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
                    C_JAL: begin
                        if (state == S_T3) begin bus.PCout = 1'b1; bus.REGin = JAL_REGIN; end
                        if (state == S_T4) begin bus.GRA = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
                    end
                    C_IN:   if (state == S_T3) begin bus.InPortOut = 1'b1; bus.GRA = 1'b1; bus.Rin = 1'b1; end
                    C_OUT:  if (state == S_T3) begin bus.GRA = 1'b1; bus.Rout = 1'b1; bus.OutPortIn = 1'b1; end
                    C_MFHI: if (state == S_T3) begin bus.HIout = 1'b1; bus.GRA = 1'b1; bus.Rin = 1'b1; end
                    C_MFLO: if (state == S_T3) begin bus.LOout = 1'b1; bus.GRA = 1'b1; bus.Rin = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit
//  Bench for control_unit. A queue-based model of the instruction sequences
//  predicts the full strobe word every cycle, and one compare process checks
//  the DUT against it on each negedge. The main process drives directed
//  instruction streams. It also posts literal expected words for chosen
//  cycles, and the compare process checks those against the DUT as well.
module tb_control_unit;

    logic clk = 1'b0;
    logic clr;

    control_unit_if #(.OPW(5), .NREG(16)) bus ();
    control_unit #(.OPW(5), .NREG(16)) dut (.clk(clk), .clr(clr), .bus(bus));

    always #5 clk = ~clk;

    localparam logic [44:0] PCOUT = 45'd1 << 0,  ZLOWOUT = 45'd1 << 1,  ZHIGHOUT = 45'd1 << 2;
    localparam logic [44:0] MDROUT = 45'd1 << 3, HIOUT = 45'd1 << 4,    LOOUT = 45'd1 << 5;
    localparam logic [44:0] COUT = 45'd1 << 6,   INPORTOUT = 45'd1 << 7, PCIN = 45'd1 << 8;
    localparam logic [44:0] MARIN = 45'd1 << 9,  MDRIN = 45'd1 << 10,   IRIN = 45'd1 << 11;
    localparam logic [44:0] YIN = 45'd1 << 12,   ZLOWIN = 45'd1 << 13,  ZHIGHIN = 45'd1 << 14;
    localparam logic [44:0] HIIN = 45'd1 << 15,  LOIN = 45'd1 << 16,    CONIN = 45'd1 << 17;
    localparam logic [44:0] OUTPORTIN = 45'd1 << 18, INCPC = 45'd1 << 19, READ = 45'd1 << 20;
    localparam logic [44:0] RAMIN = 45'd1 << 21, GRA = 45'd1 << 22,     GRB = 45'd1 << 23;
    localparam logic [44:0] GRC = 45'd1 << 24,   BAOUT = 45'd1 << 25,   RIN = 45'd1 << 26;
    localparam logic [44:0] ROUT = 45'd1 << 27,  REG15 = 45'd1 << 43,   RUN = 45'd1 << 44;
    localparam logic [44:0] DRIVERS = 45'hFF;
    localparam logic [44:0] T0_W = PCOUT | MARIN | INCPC | ZLOWIN | RUN;

    typedef struct {
        logic [44:0] w;
        bit          e;
        bit          h;
        bit          br;
    } step_t;

    step_t       mq[$];
    step_t       hd;
    int          mode;
    int          n_vec;
    int          n_miss;
    logic [44:0] got, exp_w;

    int          pin_seq = 0;
    int          pin_done = 0;
    string       pin_name;
    logic [44:0] pin_val;

    wire [44:0] dut_vec = {bus.Run, bus.REGin, bus.Rout, bus.Rin, bus.BAout, bus.GRC, bus.GRB, bus.GRA,
                           bus.RAMin, bus.Read, bus.IncPC, bus.OutPortIn, bus.CONin, bus.LOin, bus.HIin,
                           bus.ZHighIn, bus.ZLowIn, bus.Yin, bus.IRin, bus.MDRin, bus.MARin, bus.PCin,
                           bus.InPortOut, bus.Cout, bus.LOout, bus.HIout, bus.MDRout, bus.ZHighout,
                           bus.ZLowout, bus.PCout};

    function automatic void push(logic [44:0] w, bit e = 1'b0, bit h = 1'b0, bit br = 1'b0);
        step_t s;
        s.w = w; s.e = e; s.h = h; s.br = br;
        mq.push_back(s);
    endfunction

    function automatic void load_fetch();
        push(PCOUT | MARIN | INCPC | ZLOWIN);
        push(ZLOWOUT | PCIN | READ | MDRIN);
        push(MDROUT | IRIN);
    endfunction

    // Execute sequence of each opcode, listed state by state
    function automatic void load_exec(int op);
        if (op <= 2) begin
            push(GRB | BAOUT | YIN);
            push(COUT | ZLOWIN);
            if (op == 1) push(ZLOWOUT | GRA | RIN, 1'b1);
            else begin
                push(ZLOWOUT | MARIN);
                if (op == 0) begin push(READ | MDRIN); push(MDROUT | GRA | RIN, 1'b1); end
                else         begin push(GRA | ROUT | MDRIN); push(RAMIN, 1'b1); end
            end
        end else if (op <= 14) begin
            push(GRB | ROUT | YIN);
            push((op >= 12) ? (COUT | ZLOWIN) : (GRC | ROUT | ZLOWIN));
            push(ZLOWOUT | GRA | RIN, 1'b1);
        end else if (op <= 16) begin
            push(GRA | ROUT | YIN);
            push(GRB | ROUT | ZHIGHIN | ZLOWIN);
            push(ZLOWOUT | LOIN);
            push(ZHIGHOUT | HIIN, 1'b1);
        end else if (op <= 18) begin
            push(GRB | ROUT | ZLOWIN);
            push(ZLOWOUT | GRA | RIN, 1'b1);
        end else if (op == 19) begin
            push(GRA | ROUT | CONIN);
            push(PCOUT | YIN);
            push(COUT | ZLOWIN);
            push(ZLOWOUT, 1'b1, 1'b0, 1'b1);
        end else if (op == 20) push(GRA | ROUT | PCIN, 1'b1);
        else if (op == 21) begin push(PCOUT | REG15); push(GRA | ROUT | PCIN, 1'b1); end
        else if (op == 22) push(INPORTOUT | GRA | RIN, 1'b1);
        else if (op == 23) push(GRA | ROUT | OUTPORTIN, 1'b1);
        else if (op == 24) push(HIOUT | GRA | RIN, 1'b1);
        else if (op == 25) push(LOOUT | GRA | RIN, 1'b1);
        else if (op == 27) push('0, 1'b0, 1'b1);
        else push('0, 1'b1);
    endfunction

    // Compare process: check this cycle, then advance the model with the
    // inputs the DUT will sample on the coming posedge
    initial begin
        n_vec = 0; n_miss = 0; mode = 0;
        forever begin
            @(negedge clk);
            got = dut_vec;
            exp_w = '0;
            if (clr && mode == 1) begin
                if (mq.size() == 0) exp_w = RUN;
                else begin
                    exp_w = mq[0].w | RUN;
                    if (mq[0].br && bus.CON_FF) exp_w = exp_w | PCIN;
                end
            end
            n_vec++;
            if (got !== exp_w) begin
                n_miss++;
                $display("[TB] FAIL model t=%0t got=%h want=%h", $time, got, exp_w);
            end
            n_vec++;
            if ($countones(got & DRIVERS) > 1) begin
                n_miss++;
                $display("[TB] FAIL one_driver t=%0t got=%h want at most one of %h", $time, got, DRIVERS);
            end
            if (pin_seq != pin_done) begin
                pin_done = pin_seq;
                n_vec++;
                if (got !== pin_val) begin
                    n_miss++;
                    $display("[TB] FAIL %s t=%0t got=%h want=%h", pin_name, $time, got, pin_val);
                end
            end
            if (!clr) begin
                mode = 0;
                mq.delete();
            end else if (mode == 0) begin
                mode = 1;
                load_fetch();
            end else if (mode == 1 && mq.size() != 0) begin
                hd = mq.pop_front();
                if (hd.h) mode = 2;
                else if (hd.e) begin
                    if (bus.Stop) mode = 2;
                    else load_fetch();
                end else if (mq.size() == 0) load_exec(int'(bus.opcode));
            end
        end
    end

    task automatic apply_stimulus(input logic [4:0] op, input logic con, input logic stop, input int n);
        bus.opcode = op;
        bus.CON_FF = con;
        bus.Stop   = stop;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check_output(input string name, input logic [44:0] val);
        pin_name = name;
        pin_val  = val;
        pin_seq++;
    endtask

    int ops[18]  = '{1, 2, 3, 11, 12, 14, 16, 17, 18, 20, 21, 22, 23, 24, 25, 26, 28, 31};
    int lats[18] = '{6, 8, 6, 6,  6,  6,  7,  5,  5,  4,  5,  4,  4,  4,  4,  4,  4,  4};

    initial begin
        clr = 1'b0;
        bus.opcode = '0; bus.CON_FF = 1'b0; bus.Stop = 1'b0;

        // Reset held, then released
        apply_stimulus(5'd0, 1'b0, 1'b0, 3);
        check_output("reset_held", '0);
        apply_stimulus(5'd0, 1'b0, 1'b0, 1);
        clr = 1'b1;
        check_output("rst_state", '0);
        apply_stimulus(5'd0, 1'b0, 1'b0, 1);
        check_output("t0_first", T0_W);

        // ld (IR 0x00800075)
        apply_stimulus(5'd0, 1'b0, 1'b0, 3); check_output("ld_t3", GRB | BAOUT | YIN | RUN);
        apply_stimulus(5'd0, 1'b0, 1'b0, 1); check_output("ld_t4", COUT | ZLOWIN | RUN);
        apply_stimulus(5'd0, 1'b0, 1'b0, 1); check_output("ld_t5", ZLOWOUT | MARIN | RUN);
        apply_stimulus(5'd0, 1'b0, 1'b0, 1); check_output("ld_t6", READ | MDRIN | RUN);
        apply_stimulus(5'd0, 1'b0, 1'b0, 1); check_output("ld_t7", MDROUT | GRA | RIN | RUN);
        apply_stimulus(5'd0, 1'b0, 1'b0, 1); check_output("ld_next_t0", T0_W);

        // br taken, then not taken
        apply_stimulus(5'd19, 1'b1, 1'b0, 6); check_output("br_t6_taken", ZLOWOUT | PCIN | RUN);
        apply_stimulus(5'd19, 1'b1, 1'b0, 1); check_output("br_next_t0", T0_W);
        apply_stimulus(5'd19, 1'b0, 1'b0, 6); check_output("br_t6_not_taken", ZLOWOUT | RUN);
        apply_stimulus(5'd19, 1'b0, 1'b0, 1); check_output("br2_next_t0", T0_W);

        // mul: LO then HI on separate cycles
        apply_stimulus(5'd15, 1'b0, 1'b0, 5); check_output("mul_t5", ZLOWOUT | LOIN | RUN);
        apply_stimulus(5'd15, 1'b0, 1'b0, 1); check_output("mul_t6", ZHIGHOUT | HIIN | RUN);
        apply_stimulus(5'd15, 1'b0, 1'b0, 1); check_output("mul_next_t0", T0_W);

        // jal writes register 15 directly
        apply_stimulus(5'd21, 1'b0, 1'b0, 3); check_output("jal_t3", PCOUT | REG15 | RUN);
        apply_stimulus(5'd21, 1'b0, 1'b0, 2); check_output("jal_next_t0", T0_W);

        // Per-opcode fetch-to-fetch latency
        for (int i = 0; i < 18; i++) begin
            apply_stimulus(5'(ops[i]), 1'b0, 1'b0, lats[i]);
            check_output($sformatf("latency_op%0d", ops[i]), T0_W);
        end

        // Stop raised in T4 of add: add completes, then HALT holds
        apply_stimulus(5'd3, 1'b0, 1'b0, 4);
        apply_stimulus(5'd3, 1'b0, 1'b1, 1); check_output("add_t5_stop", ZLOWOUT | GRA | RIN | RUN);
        apply_stimulus(5'd3, 1'b0, 1'b1, 1); check_output("halt_entry", '0);
        apply_stimulus(5'd3, 1'b0, 1'b1, 20); check_output("halt_20", '0);
        apply_stimulus(5'd3, 1'b0, 1'b0, 2); check_output("halt_after_stop_low", '0);

        // clr out of HALT, then abort st in T5
        clr = 1'b0; check_output("clr_from_halt", '0);
        apply_stimulus(5'd2, 1'b0, 1'b0, 1);
        clr = 1'b1;
        apply_stimulus(5'd2, 1'b0, 1'b0, 1); check_output("restart_t0", T0_W);
        apply_stimulus(5'd2, 1'b0, 1'b0, 5);
        clr = 1'b0; check_output("st_abort_t5", '0);
        apply_stimulus(5'd2, 1'b0, 1'b0, 2);
        clr = 1'b1;
        apply_stimulus(5'd2, 1'b0, 1'b0, 1); check_output("st_restart_t0", T0_W);
        apply_stimulus(5'd2, 1'b0, 1'b0, 8); check_output("st_full_next_t0", T0_W);

        // Stop during nop's T3
        apply_stimulus(5'd26, 1'b0, 1'b1, 3); check_output("nop_t3", RUN);
        apply_stimulus(5'd26, 1'b0, 1'b1, 1); check_output("nop_halt", '0);

        // halt instruction
        clr = 1'b0;
        apply_stimulus(5'd27, 1'b0, 1'b0, 1);
        clr = 1'b1;
        apply_stimulus(5'd27, 1'b0, 1'b0, 1); check_output("halt_op_t0", T0_W);
        apply_stimulus(5'd27, 1'b0, 1'b0, 3); check_output("halt_op_t3", RUN);
        apply_stimulus(5'd27, 1'b0, 1'b0, 1); check_output("halt_op_halted", '0);
        apply_stimulus(5'd27, 1'b0, 1'b0, 3); check_output("halt_op_held", '0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
